// File: rtl/bus85_pkg.sv
// bus85_pkg: shared types and constants for the 8085-style bus memory slave.
//   state_e      - bus-cycle FSM states
//   FETCH_STATUS - {s1,s0} value that marks an opcode fetch
//   CNTSIZE      - width of the opcode-fetch counter
package bus85_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_DATA,
        ST_DONE
    } state_e;

    localparam logic [1:0] FETCH_STATUS = 2'b11;
    localparam int         CNTSIZE      = 16;

endpackage

// File: rtl/bus85_mem_if.sv
// bus85_mem_if: multiplexed 8085-style bus between a core (master) and a
// memory slave.
//   ad_in/ad_out/ad_oe - multiplexed address/data bus, split by direction
//   addr               - high address bits
//   ale                - address latch enable, active high
//   rd_, wr_           - read / write strobes, active low
//   iom_               - 0 = memory cycle, 1 = I/O cycle
//   s1, s0             - bus status (11 = opcode fetch)
//   ready              - slave wait request, low = wait
interface bus85_mem_if #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 16
);
    logic [DATASIZE-1:0]          ad_in;
    logic [DATASIZE-1:0]          ad_out;
    logic                         ad_oe;
    logic [ADDRSIZE-DATASIZE-1:0] addr;
    logic                         ale;
    logic                         rd_;
    logic                         wr_;
    logic                         iom_;
    logic                         s1;
    logic                         s0;
    logic                         ready;

    modport master (
        output ad_in, addr, ale, rd_, wr_, iom_, s1, s0,
        input  ad_out, ad_oe, ready
    );

    modport slave (
        input  ad_in, addr, ale, rd_, wr_, iom_, s1, s0,
        output ad_out, ad_oe, ready
    );
endinterface

// File: rtl/bus85_ram.sv
// bus85_ram: single-port-style RAM with synchronous write and a registered
// read port. The read register is reset to zero; the array is not.
//   clk, rst_    - clock, synchronous active-low reset (read register only)
//   we/waddr/wdata - write port
//   re/raddr     - read request; rdata updates on the edge re is high
//   rdata        - registered read data
module bus85_ram #(
    parameter int DATASIZE = 8,
    parameter int MEMDEPTH = 4096
) (
    input  logic                        clk,
    input  logic                        rst_,
    input  logic                        we,
    input  logic [$clog2(MEMDEPTH)-1:0] waddr,
    input  logic [DATASIZE-1:0]         wdata,
    input  logic                        re,
    input  logic [$clog2(MEMDEPTH)-1:0] raddr,
    output logic [DATASIZE-1:0]         rdata
);
    logic [DATASIZE-1:0] mem_q [MEMDEPTH];
    logic [DATASIZE-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) rdata_d = mem_q[raddr];
    end

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_) rdata_q <= '0;
        else       rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/bus85_mem.sv
// bus85_mem: memory slave for the core85 multiplexed bus.
// Latches the address on ALE, decodes a MEMDEPTH-word window at BASEADDR,
// inserts WAITCNT wait states through ready, counts opcode fetches that hit
// the window and flags rd_/wr_ asserted together as a sticky bus error.
//   clk, rst_  - clock, synchronous active-low reset
//   bus        - slave side of the multiplexed bus
//   fetch_cnt  - in-window opcode fetch reads (wraps)
//   berr       - sticky protocol error
module bus85_mem import bus85_pkg::*; #(
    parameter int          DATASIZE = 8,
    parameter int          ADDRSIZE = 16,
    parameter int          MEMDEPTH = 4096,
    parameter int unsigned BASEADDR = 32'h0000,
    parameter int          WAITCNT  = 0
) (
    input  logic               clk,
    input  logic               rst_,
    bus85_mem_if.slave         bus,
    output logic [CNTSIZE-1:0] fetch_cnt,
    output logic               berr
);
    localparam int         AW        = $clog2(MEMDEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAITCNT > 0) ? 4'(WAITCNT - 1) : 4'd0;

    state_e               state_q, state_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic                 sel_q, sel_d;
    logic                 fetch_q, fetch_d;
    logic                 is_rd_q, is_rd_d;
    logic [3:0]           wcnt_q, wcnt_d;
    logic                 ad_oe_q, ad_oe_d;
    logic                 ready_q, ready_d;
    logic                 berr_q, berr_d;
    logic [CNTSIZE-1:0]   fetch_cnt_q, fetch_cnt_d;

    logic [ADDRSIZE-1:0]  full_addr;
    logic                 in_win;
    logic                 rd_go, wr_go, both, released;
    logic                 ram_we, ram_re;
    logic [DATASIZE-1:0]  ram_rdata;

    assign full_addr = {bus.addr, bus.ad_in};
    // Window is aligned to MEMDEPTH, so comparing the bits above the RAM
    // index is the whole range check.
    assign in_win    = (32'(full_addr) >> AW) == (BASEADDR >> AW);
    assign rd_go     = !bus.rd_ &&  bus.wr_;
    assign wr_go     =  bus.rd_ && !bus.wr_;
    assign both      = !bus.rd_ && !bus.wr_;
    // The strobe that started this access has gone back high.
    assign released  = is_rd_q ? bus.rd_ : bus.wr_;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state; ALE restarts the cycle from any state
    always_comb begin
        state_d = state_q;
        if (bus.ale) begin
            state_d = ST_ADDR;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_ADDR: begin
                    if (both)
                        state_d = ST_DONE;
                    else if (rd_go || wr_go)
                        state_d = !sel_q ? ST_DONE :
                                  (WAITCNT > 0) ? ST_WAIT : ST_DATA;
                end
                ST_WAIT: begin
                    if (released)            state_d = ST_IDLE;
                    else if (wcnt_q == '0)   state_d = ST_DATA;
                end
                ST_DATA: state_d = ST_DONE;
                ST_DONE: if (bus.rd_ && bus.wr_) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs and datapath
    always_comb begin
        idx_d       = idx_q;
        sel_d       = sel_q;
        fetch_d     = fetch_q;
        is_rd_d     = is_rd_q;
        wcnt_d      = wcnt_q;
        ad_oe_d     = ad_oe_q;
        berr_d      = berr_q;
        fetch_cnt_d = fetch_cnt_q;
        ram_we      = 1'b0;
        ram_re      = 1'b0;
        ready_d     = (state_d != ST_WAIT);

        if (bus.ale) begin
            idx_d   = full_addr[AW-1:0];
            sel_d   = !bus.iom_ && in_win;
            fetch_d = ({bus.s1, bus.s0} == FETCH_STATUS);
            ad_oe_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (both) begin
                        berr_d = 1'b1;
                    end else if (rd_go || wr_go) begin
                        is_rd_d = rd_go;
                        wcnt_d  = WAIT_LOAD;
                        ram_re  = rd_go && sel_q;
                    end
                end
                ST_WAIT: begin
                    if (!released) begin
                        if (wcnt_q != '0) wcnt_d = wcnt_q - 4'd1;
                        else              ram_re = is_rd_q;  // refresh on exit
                    end
                end
                ST_DATA: begin
                    ad_oe_d = is_rd_q && !bus.rd_;
                    ram_we  = !is_rd_q;
                    if (is_rd_q && fetch_q) fetch_cnt_d = fetch_cnt_q + CNTSIZE'(1);
                end
                ST_DONE: if (bus.rd_) ad_oe_d = 1'b0;
                default: ;
            endcase
        end

        // A reset edge drops a write that would otherwise land on it.
        if (!rst_) ram_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            idx_q       <= '0;
            sel_q       <= 1'b0;
            fetch_q     <= 1'b0;
            is_rd_q     <= 1'b0;
            wcnt_q      <= '0;
            ad_oe_q     <= 1'b0;
            ready_q     <= 1'b1;
            berr_q      <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            idx_q       <= idx_d;
            sel_q       <= sel_d;
            fetch_q     <= fetch_d;
            is_rd_q     <= is_rd_d;
            wcnt_q      <= wcnt_d;
            ad_oe_q     <= ad_oe_d;
            ready_q     <= ready_d;
            berr_q      <= berr_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    bus85_ram #(.DATASIZE(DATASIZE), .MEMDEPTH(MEMDEPTH)) u_ram (
        .clk   (clk),
        .rst_  (rst_),
        .we    (ram_we),
        .waddr (idx_q),
        .wdata (bus.ad_in),
        .re    (ram_re),
        .raddr (idx_q),
        .rdata (ram_rdata)
    );

    assign bus.ad_out = ram_rdata;
    assign bus.ad_oe  = ad_oe_q;
    assign bus.ready  = ready_q;
    assign fetch_cnt  = fetch_cnt_q;
    assign berr       = berr_q;
endmodule

// File: tb/tb_bus85_mem.sv
// Bench for bus85_mem: three instances share one bus driver
//   u0: BASEADDR=0000 WAITCNT=0, u1: BASEADDR=0000 WAITCNT=3,
//   u2: BASEADDR=8000 WAITCNT=4
// Expected outputs come from a timing model keyed on the cycle index within
// each bus transaction; a negedge process compares every cycle.
module tb_bus85_mem;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, ale, rd_n, wr_n, iom_n;
    logic [1:0] st;
    logic [7:0] ad_in, addr_hi;

    bus85_mem_if #(.DATASIZE(8), .ADDRSIZE(16)) if0 (), if1 (), if2 ();

    assign if0.ad_in = ad_in; assign if0.addr = addr_hi; assign if0.ale = ale;
    assign if0.rd_ = rd_n; assign if0.wr_ = wr_n; assign if0.iom_ = iom_n;
    assign if0.s1 = st[1]; assign if0.s0 = st[0];
    assign if1.ad_in = ad_in; assign if1.addr = addr_hi; assign if1.ale = ale;
    assign if1.rd_ = rd_n; assign if1.wr_ = wr_n; assign if1.iom_ = iom_n;
    assign if1.s1 = st[1]; assign if1.s0 = st[0];
    assign if2.ad_in = ad_in; assign if2.addr = addr_hi; assign if2.ale = ale;
    assign if2.rd_ = rd_n; assign if2.wr_ = wr_n; assign if2.iom_ = iom_n;
    assign if2.s1 = st[1]; assign if2.s0 = st[0];

    logic [15:0] fc [3];
    logic        be [3];
    logic        d_ready [3];
    logic        d_oe [3];
    logic [7:0]  d_out [3];

    bus85_mem #(.DATASIZE(8), .ADDRSIZE(16), .MEMDEPTH(4096), .BASEADDR(32'h0000), .WAITCNT(0))
        u0 (.clk(clk), .rst_(rst_n), .bus(if0), .fetch_cnt(fc[0]), .berr(be[0]));
    bus85_mem #(.DATASIZE(8), .ADDRSIZE(16), .MEMDEPTH(4096), .BASEADDR(32'h0000), .WAITCNT(3))
        u1 (.clk(clk), .rst_(rst_n), .bus(if1), .fetch_cnt(fc[1]), .berr(be[1]));
    bus85_mem #(.DATASIZE(8), .ADDRSIZE(16), .MEMDEPTH(4096), .BASEADDR(32'h8000), .WAITCNT(4))
        u2 (.clk(clk), .rst_(rst_n), .bus(if2), .fetch_cnt(fc[2]), .berr(be[2]));

    assign d_ready[0] = if0.ready; assign d_oe[0] = if0.ad_oe; assign d_out[0] = if0.ad_out;
    assign d_ready[1] = if1.ready; assign d_oe[1] = if1.ad_oe; assign d_out[1] = if1.ad_out;
    assign d_ready[2] = if2.ready; assign d_oe[2] = if2.ad_oe; assign d_out[2] = if2.ad_out;

    // Model
    int          nw   [3] = '{0, 3, 4};
    int unsigned base [3] = '{32'h0000, 32'h0000, 32'h8000};
    logic [7:0]  mm [3][65536];
    logic        e_ready [3];
    logic        e_oe [3];
    logic        e_berr [3];
    logic [7:0]  e_out [3];
    logic [15:0] e_fc [3];
    int          lowcnt [3];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int u, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h want %0h at %0t", name, u, act, exp, $time);
        end
    endtask

    task automatic model_reset_u(input int u);
        e_ready[u] = 1'b1; e_oe[u] = 1'b0; e_out[u] = 8'h00;
        e_fc[u] = 16'h0000; e_berr[u] = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int u = 0; u < 3; u++) begin
                check("ready",     u, 32'(d_ready[u]), 32'(e_ready[u]));
                check("ad_oe",     u, 32'(d_oe[u]),    32'(e_oe[u]));
                check("ad_out",    u, 32'(d_out[u]),   32'(e_out[u]));
                check("fetch_cnt", u, 32'(fc[u]),      32'(e_fc[u]));
                check("berr",      u, 32'(be[u]),      32'(e_berr[u]));
                if (!d_ready[u]) lowcnt[u]++;
            end
        end
    end

    // One bus cycle. kind: 0 read, 1 write, 2 rd_+wr_ together.
    // Strobe is low at edges 1..hold (edge 0 samples ALE); rst_at is the edge
    // index where rst_ is sampled low, -1 for none.
    task automatic xact(input int kind, input logic [15:0] a, input logic [7:0] d,
                        input logic [1:0] sv, input logic iom, input int hold,
                        input int rst_at);
        bit dead [3];
        for (int u = 0; u < 3; u++) begin dead[u] = 1'b0; lowcnt[u] = 0; end
        ale = 1'b1; addr_hi = a[15:8]; ad_in = a[7:0]; st = sv; iom_n = iom;
        rd_n = 1'b1; wr_n = 1'b1; rst_n = 1'b1;
        for (int j = 0; j <= hold + 2; j++) begin
            @(posedge clk); #1;
            for (int u = 0; u < 3; u++) begin
                int n;
                bit inwin, complete;
                n        = nw[u];
                inwin    = !iom && (32'(a) >= base[u]) && (32'(a) < base[u] + 32'd4096);
                complete = hold >= n + 1;
                if (j == rst_at) begin
                    model_reset_u(u);
                    dead[u] = 1'b1;
                end else if (!dead[u]) begin
                    if (j == 0) begin
                        e_oe[u] = 1'b0; e_ready[u] = 1'b1;
                    end else if (kind == 2) begin
                        if (j == 1) e_berr[u] = 1'b1;
                    end else if (inwin) begin
                        e_ready[u] = !(j <= ((n < hold) ? n : hold));
                        if (kind == 0 && j == 1) e_out[u] = mm[u][a];
                        if (complete) begin
                            if (kind == 0) e_oe[u] = (j >= n + 2) && (j <= hold);
                            if (j == n + 2) begin
                                if (kind == 1)        mm[u][a] = d;
                                else if (sv == 2'b11) e_fc[u] = e_fc[u] + 16'd1;
                            end
                        end
                    end
                end
            end
            ale   = 1'b0;
            ad_in = d;
            rd_n  = !(kind != 1 && j + 1 <= hold);
            wr_n  = !(kind != 0 && j + 1 <= hold);
            rst_n = !(j + 1 == rst_at);
        end
    endtask

    initial begin
        rst_n = 1'b0; ale = 1'b0; rd_n = 1'b1; wr_n = 1'b1; iom_n = 1'b0;
        st = 2'b10; ad_in = 8'h00; addr_hi = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int u = 0; u < 3; u++) model_reset_u(u);
        chk_en = 1'b1;

        // Reset state
        check("rst_ready", 0, 32'(d_ready[0]), 32'd1);
        check("rst_oe",    0, 32'(d_oe[0]),    32'd0);
        check("rst_out",   0, 32'(d_out[0]),   32'h00);
        check("rst_fc",    0, 32'(fc[0]),      32'd0);
        check("rst_berr",  0, 32'(be[0]),      32'd0);

        // Preload
        xact(1, 16'h0010, 8'hA5, 2'b10, 1'b0, 6, -1);
        xact(1, 16'h0020, 8'h5A, 2'b10, 1'b0, 6, -1);
        xact(1, 16'h8020, 8'hC3, 2'b10, 1'b0, 6, -1);
        xact(1, 16'h8030, 8'h11, 2'b10, 1'b0, 6, -1);

        // Reads, with and without wait states
        xact(0, 16'h0010, 8'h00, 2'b10, 1'b0, 6, -1);
        check("rd10_out",  0, 32'(d_out[0]), 32'hA5);
        check("rd10_low",  0, 32'(lowcnt[0]), 32'd0);
        check("rd10_low",  1, 32'(lowcnt[1]), 32'd3);
        xact(0, 16'h0020, 8'h00, 2'b10, 1'b0, 6, -1);
        check("rd20_out",  1, 32'(d_out[1]), 32'h5A);
        check("rd20_low",  1, 32'(lowcnt[1]), 32'd3);
        xact(0, 16'h8020, 8'h00, 2'b10, 1'b0, 6, -1);
        check("rd8020_out", 2, 32'(d_out[2]), 32'hC3);
        check("rd8020_low", 2, 32'(lowcnt[2]), 32'd4);

        // Out of window, then I/O cycle inside u2's window
        xact(0, 16'h1234, 8'h00, 2'b10, 1'b0, 6, -1);
        check("oow_out", 0, 32'(d_out[0]), 32'h5A);
        check("oow_low", 2, 32'(lowcnt[2]), 32'd0);
        xact(0, 16'h8000, 8'h00, 2'b10, 1'b1, 6, -1);
        check("io_out", 2, 32'(d_out[2]), 32'hC3);
        check("io_low", 2, 32'(lowcnt[2]), 32'd0);

        // Opcode fetch counting
        for (int i = 0; i < 5; i++) xact(0, 16'h0010, 8'h00, 2'b11, 1'b0, 6, -1);
        for (int i = 0; i < 3; i++) xact(0, 16'h0020, 8'h00, 2'b10, 1'b0, 6, -1);
        check("fetch", 0, 32'(fc[0]), 32'd5);
        check("fetch", 1, 32'(fc[1]), 32'd5);
        check("fetch", 2, 32'(fc[2]), 32'd0);

        // Write strobe released early: u1 abandons in WAIT, u0 completes
        xact(1, 16'h0020, 8'hFF, 2'b10, 1'b0, 2, -1);
        xact(0, 16'h0020, 8'h00, 2'b10, 1'b0, 6, -1);
        check("early_out", 0, 32'(d_out[0]), 32'hFF);
        check("early_out", 1, 32'(d_out[1]), 32'h5A);

        // Protocol error: sticky, RAM untouched
        xact(2, 16'h0010, 8'h00, 2'b10, 1'b0, 6, -1);
        check("berr_set", 0, 32'(be[0]), 32'd1);
        check("berr_set", 2, 32'(be[2]), 32'd1);
        xact(0, 16'h0010, 8'h00, 2'b10, 1'b0, 6, -1);
        check("berr_sticky", 0, 32'(be[0]), 32'd1);
        check("berr_ram",    0, 32'(d_out[0]), 32'hA5);

        // Reset during the second wait cycle of a write
        xact(1, 16'h8030, 8'h3C, 2'b10, 1'b0, 6, 3);
        check("rstw_low",  2, 32'(lowcnt[2]), 32'd2);
        check("rstw_berr", 0, 32'(be[0]), 32'd0);
        check("rstw_fc",   0, 32'(fc[0]), 32'd0);
        xact(0, 16'h8030, 8'h00, 2'b10, 1'b0, 6, -1);
        check("rstw_old", 2, 32'(d_out[2]), 32'h11);

        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus85_mem.md
# bus85_mem

Synthesizable memory slave for the 8085-style multiplexed bus driven by `core85`. It latches the address on ALE, serves reads and writes to an internal RAM window, and inserts a parameterised number of wait states via `ready`. It also counts opcode fetches and flags bus protocol errors. It replaces the behavioural memory in core-level benches and is the on-chip RAM in SoC builds.

## Interface
- `DATASIZE`, 8: data and low-address bus width.
- `ADDRSIZE`, 16: full address width; the high part is `ADDRSIZE-DATASIZE` bits.
- `MEMDEPTH`, 4096: RAM words; power of two.
- `BASEADDR`, 16'h0000: first address of the window; aligned to `MEMDEPTH`.
- `WAITCNT`, 0: wait states per access, 0..15.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_` in 1: synchronous, active-low reset.
- `ad_in` in DATASIZE: multiplexed address/data bus, input side.
- `ad_out` out DATASIZE: read data driven onto the bus.
- `ad_oe` out 1: output enable for `ad_out`.
- `addr` in ADDRSIZE-DATASIZE: high address byte.
- `ale` in 1: address latch enable, active high.
- `rd_`, `wr_` in 1: read and write strobes, active low.
- `iom_` in 1: 0 selects memory; 1 selects I/O, which this block ignores.
- `s1`, `s0` in 1: bus status; 11 means opcode fetch.
- `ready` out 1: wait-state request to the core; low means wait.
- `fetch_cnt` out 16: count of opcode fetches that hit the window.
- `berr` out 1: sticky protocol-error flag.

## Operation
- Reset values: `ad_out`=0, `ad_oe`=0, `ready`=1, `fetch_cnt`=0, `berr`=0, state IDLE. RAM contents are not reset.
- States: IDLE, ADDR, WAIT, DATA, DONE.
- `ale`=1 in any state:
  - Latch `{addr, ad_in}` and go to ADDR.
  - Set `sel` = (`iom_`==0) and the address is inside [BASEADDR, BASEADDR+MEMDEPTH).
  - Latch fetch = `s1&s0`.
  - A new ALE aborts any cycle in progress: `ad_oe` goes to 0 and `ready` to 1.
- ADDR:
  - `rd_`=0 and `wr_`=0 together: set `berr`=1 and go to DONE with no access.
  - Either strobe low with `sel`=1: go to WAIT if WAITCNT>0, else to DATA. A read registers `mem[latched addr - BASEADDR]` into `ad_out` on the same edge.
  - Strobe low with `sel`=0: go to DONE silently; `ready` stays 1.
- WAIT:
  - `ready`=0, wait counter loaded with WAITCNT-1.
  - When the counter reaches 0, go to DATA. The read data register is refreshed on that exit edge.
- DATA:
  - `ready`=1. A read sets `ad_oe`=1.
  - A write stores `ad_in` into RAM exactly once, on the first DATA edge.
  - If fetch is latched and the access is a read, `fetch_cnt` increments (wraps at 16'hFFFF→0).
  - Go to DONE.
- DONE: hold `ad_oe` while `rd_`=0. When both strobes are high, set `ad_oe`=0 and go to IDLE.
- Strobe released early (in WAIT): abandon the access, no write, `ready`=1, go to IDLE.

## Timing
- ALE is sampled at the rising edge; the address is valid for decode on the next edge.
- Read latency with WAITCNT=0: `rd_` is sampled low at edge t, and `ad_out`/`ad_oe` are valid after edge t+1.
- Read latency with WAITCNT=N: `ready` is low for exactly N cycles starting after edge t, and data is valid together with `ready` returning high.
- Write: RAM is updated at the edge that enters DATA+1, i.e. t+1 for N=0 and t+N+1 otherwise.
- `ad_oe` falls on the first edge where `rd_`=1.
- `rst_`=0 mid-cycle: outputs go to their reset values at that edge; a pending write is dropped.

## Structure
- Shared package `bus85_pkg`:
  - state enum.
  - `FETCH_STATUS`=2'b11.
  - `CNTSIZE`=16.
- One sub-module `bus85_ram`: synchronous write, registered read, parameterised by DATASIZE and MEMDEPTH.
- Decode, FSM, wait counter and fetch counter live in `bus85_mem`.

## Test plan
- Write then read: BASEADDR=0, WAITCNT=0. Write 8'hA5 to 16'h0010, then read 16'h0010 → `ad_out`=A5, `ad_oe`=1 one cycle after `rd_` low, `ready` never low.
- Wait states: WAITCNT=3, read 16'h0020 → `ready` low for exactly 3 cycles, data valid when `ready` rises.
- Out-of-window: BASEADDR=16'h8000, read 16'h1234, then read with `iom_`=1 at 16'h8000 → `ad_oe` stays 0 and `ready` stays 1 for both.
- Opcode fetch: 5 reads with `s1s0`=11 plus 3 reads with `s1s0`=10 → `fetch_cnt`=5.
- Protocol error: `rd_` and `wr_` low together after ALE → `berr`=1 and sticky, RAM unchanged. A following `rst_`=0 clears `berr`.
- Reset during WAIT: WAITCNT=4, pulse `rst_` low in the second wait cycle of a write of 8'h3C → `ready`=1 after that edge, and a later read of that address returns its old value.
